// File: rtl/sar_search4bit.sv
// Successive-approximation search controller that drives a magnitude comparator MSB-first.
// Define SAR_EARLY_EXIT_EN to end a search as soon as an exact match is seen.
module sar_search4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             less,
    input  logic             equal,
    input  logic             greater,
    output logic [WIDTH-1:0] guess,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             hit,
    output logic             err
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]    TOP = IW'(WIDTH-1);

    typedef enum logic [1:0] {
        IDLE,
        TEST,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] guess_q, guess_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             hit_q, hit_d;
    logic             err_q, err_d;

    logic             legal;
    logic             early_stop;
    logic [WIDTH-1:0] cur;

    // Exactly one comparator flag high: odd parity rules out zero and two, the AND rules out three.
    assign legal = (less ^ equal ^ greater) & ~(less & equal & greater);

`ifdef SAR_EARLY_EXIT_EN
    assign early_stop = equal & legal;
`else
    assign early_stop = 1'b0;
`endif

    assign cur = greater ? (guess_q & ~(ONE << idx_q)) : guess_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            guess_q  <= '0;
            result_q <= '0;
            idx_q    <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        guess_d  = guess_q;
        result_d = result_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
        err_d    = err_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    guess_d = MSB;
                    idx_d   = TOP;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = TEST;
                end else begin
                    state_d = IDLE;
                end
            end

            TEST: begin
                if (equal) begin
                    hit_d = 1'b1;
                end
                if (!legal) begin
                    err_d = 1'b1;
                end

                // On an early match guess already equals the target, so it is left in place.
                if (early_stop) begin
                    result_d = guess_q;
                    state_d  = DONE;
                end else if (idx_q == '0) begin
                    result_d = cur;
                    guess_d  = cur;
                    state_d  = DONE;
                end else begin
                    guess_d = cur | (ONE << (idx_q - IW'(1)));
                    idx_d   = idx_q - IW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign guess  = guess_q;
    assign busy   = (state_q == TEST);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign hit    = hit_q;
    assign err    = err_q;

endmodule

// File: doc/sar_search4bit.md
# sar_search4bit

Successive-approximation search controller: the driving side of the magnitude comparator. It owns the comparator's first operand (`guess`), reads back `less`/`equal`/`greater` against an unknown target on the second operand, and binary-searches the target value MSB-first. It sits next to a combinational `comparator4bit` instance, which is wired externally. It reports the result with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 4: operand width in bits; legal range ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a new search; accepted only when `busy`=0.
- `less` input 1: comparator result, guess < target.
- `equal` input 1: comparator result, guess == target.
- `greater` input 1: comparator result, guess > target.
- `guess` output WIDTH: registered trial value driven to comparator operand w0.
- `busy` output 1: search in progress.
- `done` output 1: one-cycle pulse; `result`, `hit` and `err` are valid from this cycle on.
- `result` output WIDTH: final value, held until the next accepted `start`.
- `hit` output 1: an exact match (`equal`=1) was sampled during this search.
- `err` output 1: an illegal comparator code was sampled during this search.

## Operation
- States:
  - IDLE: wait for `start`.
  - TEST: `idx` counts WIDTH-1 down to 0.
  - DONE: lasts one cycle.
- IDLE or DONE with `start`=1:
  - `guess`←1<<(WIDTH-1), `idx`←WIDTH-1.
  - Clear `hit` and `err`; go to TEST.
- TEST, every edge: sample the comparator against the current `guess`.
  - `keep` = !`greater`.
  - cur = `keep` ? `guess` : `guess` with bit `idx` cleared.
  - `equal`=1 sets `hit`.
  - The code is legal only when exactly one of `less`/`equal`/`greater` is high; anything else sets `err`. The decision still uses `greater` only.
- TEST with `idx`>0: `guess`←cur | (1<<(idx-1)), `idx`←idx-1.
- TEST with `idx`=0: `result`←cur, `guess`←cur; go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. A `start` sampled in DONE restarts immediately and goes to TEST.
- `start` while `busy`=1 is ignored.
- `result` equals the largest value ≤ target, which is the target itself for any in-range target.
- Boundary conditions:
  - Target 0: value 0 is never probed, so `result`=0 and `hit`=0.
  - Target 2^WIDTH-1: every step keeps its bit, so `result`=all ones.
- Reset values, all outputs: `guess`=0, `busy`=0, `done`=0, `result`=0, `hit`=0, `err`=0; state IDLE.
- Reset asserted mid-search: the search is abandoned with no `done` pulse and outputs return to their reset values.

## Timing
- Comparator path is combinational: `guess` is registered, so the comparator outputs must settle within the same cycle.
- `start` sampled at edge t0:
  - `busy`=1 after t0.
  - Comparator sampled at edges t0+1 … t0+WIDTH.
  - After t0+WIDTH: `done`=1, `busy`=0, `result` valid.
  - After t0+WIDTH+1: `done`=0.
- Fixed latency of WIDTH+1 edges from `start` to `done`; no back-pressure.
- `busy` and `done` are never high together.

## Configuration
- `SAR_EARLY_EXIT_EN` defined:
  - In TEST, `equal`=1 (with a legal code) ends the search at once: `result`←`guess`, `hit`=1, go to DONE.
  - Latency becomes k+1 edges, where k is the step at which the match occurs (1..WIDTH).
- `SAR_EARLY_EXIT_EN` undefined:
  - Always WIDTH TEST cycles.
  - `equal` only sets `hit`; `result` is identical to the early-exit build.

## Test plan
WIDTH=4; `comparator4bit` instance with w0=`guess`, w1=target.
- Target 0101, `start` pulse -> guesses 1000,0100,0110,0101; `result`=0101, `hit`=1, `err`=0, `done` after edge 4.
- Target 1000 -> without macro: guesses 1000,1100,1010,1001, `result`=1000 at edge 4. With `SAR_EARLY_EXIT_EN`: `done` after edge 1, `result`=1000.
- Targets 0000 and 1111 -> `result`=0000 with `hit`=0 (all steps `greater`); `result`=1111 with `hit`=1.
- `start` held high during a search, then a back-to-back `start` in the DONE cycle -> extra starts ignored; the second search begins with `guess`=1000 and no IDLE cycle.
- `rst_n` low at edge 2 of a search -> all outputs 0, no `done`; a new `start` after release completes normally.
- Force `less`=`greater`=1 on step 2 -> `err`=1 at `done`; `err` cleared by the next `start`.
